// File: rtl/ahb_slave_ram_pkg.sv
// ---------------------------------------------------------------------------
// ahb_slave_ram_pkg
// Shared AHB 2.0 encodings (HTRANS, HRESP, HBURST, HSIZE) and the responder
// FSM state type used by ahb_slave_ram. Also used by the matching master so
// both ends of the bus agree on the codes.
// ---------------------------------------------------------------------------
package ahb_slave_ram_pkg;

    // Transfer type codes
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Response codes (only OKAY and ERROR are ever issued by the RAM slave)
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    // Burst type codes
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Transfer size codes
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    // True when a transfer of the given size is wider than the data bus
    function automatic logic isOversize(input logic [2:0] size, input int dataWdt);
        return (32'd8 << size) > 32'(dataWdt);
    endfunction

endpackage

// File: rtl/ahb_slave_bytemem.sv
// ---------------------------------------------------------------------------
// ahb_slave_bytemem
// DEPTH x DATA_WDT storage array behind the AHB RAM slave.
//  - synchronous write with one enable per byte lane
//  - synchronous read into a registered output word
//  - a read on the same edge as a write to the same word sees the merged
//    new bytes instead of the stale array contents
// Ports:
//  i_clk     clock, rising edge
//  i_rst_n   async active-low reset (clears the read register only)
//  i_wrEn    commit write this edge
//  i_wrIdx   word index of the write
//  i_byteEn  per-lane write enables
//  i_wdata   write data, lane-positioned
//  i_rdEn    fetch word at i_rdIdx into o_rdata this edge
//  i_rdIdx   word index of the read
//  i_rdClr   clear o_rdata this edge when no read is fetched
//  o_rdata   registered read word
// ---------------------------------------------------------------------------
module ahb_slave_bytemem
    import ahb_slave_ram_pkg::*;
#(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wrEn,
    input  logic [$clog2(DEPTH)-1:0]   i_wrIdx,
    input  logic [DATA_WDT/8-1:0]      i_byteEn,
    input  logic [DATA_WDT-1:0]        i_wdata,
    input  logic                       i_rdEn,
    input  logic [$clog2(DEPTH)-1:0]   i_rdIdx,
    input  logic                       i_rdClr,
    output logic [DATA_WDT-1:0]        o_rdata
);

    localparam int NB = DATA_WDT / 8;

    logic [DATA_WDT-1:0] r_mem [DEPTH];
    logic [DATA_WDT-1:0] r_rdata;
    logic [DATA_WDT-1:0] w_fwd;

    // Read word as it will look after this edge: array contents with any
    // bytes being written to the same word this edge overlaid on top.
    always_comb begin
        w_fwd = r_mem[i_rdIdx];
        if (i_wrEn && (i_wrIdx == i_rdIdx)) begin
            for (int b = 0; b < NB; b++) begin
                if (i_byteEn[b]) begin
                    w_fwd[8*b +: 8] = i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Storage array: not reset, only enabled lanes of the addressed word change.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            for (int b = 0; b < NB; b++) begin
                if (i_byteEn[b]) begin
                    r_mem[i_wrIdx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register: loaded on a fetch, held through wait states, zeroed
    // once the phase completes so non-read phases show zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_rdEn) begin
            r_rdata <= w_fwd;
        end else if (i_rdClr) begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_slave_ram.sv
// ---------------------------------------------------------------------------
// ahb_slave_ram
// AHB 2.0 responder in front of a word-addressed RAM. Accepts SINGLE and
// incrementing bursts (BUSY allowed between beats), inserts WAIT_STATES
// wait cycles per valid data phase and gives the two-cycle ERROR response
// for out-of-range, misaligned or oversize transfers.
// Ports:
//  i_hclk      AHB clock, rising edge
//  i_hreset_n  async active-low reset
//  i_hsel      slave select from the decoder
//  i_haddr     byte address (address phase)
//  i_htrans    IDLE/BUSY/NONSEQ/SEQ
//  i_hwrite    1 = write
//  i_hsize     transfer size
//  i_hburst    burst type, not used for decoding
//  i_hwdata    write data (data phase)
//  i_hready    bus-wide HREADY
//  o_hready    slave HREADYout
//  o_hresp     OKAY/ERROR
//  o_hrdata    read data, valid when o_hready=1 in a read data phase
// ---------------------------------------------------------------------------
module ahb_slave_ram
    import ahb_slave_ram_pkg::*;
#(
    parameter int DATA_WDT    = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 i_hclk,
    input  logic                 i_hreset_n,
    input  logic                 i_hsel,
    input  logic [31:0]          i_haddr,
    input  logic [1:0]           i_htrans,
    input  logic                 i_hwrite,
    input  logic [2:0]           i_hsize,
    input  logic [2:0]           i_hburst,
    input  logic [DATA_WDT-1:0]  i_hwdata,
    input  logic                 i_hready,
    output logic                 o_hready,
    output logic [1:0]           o_hresp,
    output logic [DATA_WDT-1:0]  o_hrdata
);

    localparam int NB    = DATA_WDT / 8;
    localparam int LSB   = $clog2(NB);
    localparam int AW    = $clog2(DEPTH);
    localparam int BYTES = DEPTH * NB;

    slv_state_t        r_state;
    logic [3:0]        r_wctr;
    logic              r_hready;
    logic [1:0]        r_hresp;
    logic              r_pend;
    logic              r_pendWrite;
    logic [31:0]       r_addr;
    logic [2:0]        r_size;

    logic              w_accept;
    logic              w_error;
    logic              w_acceptOk;
    logic              w_commit;
    logic              w_rdEn;
    logic [NB-1:0]     w_byteEn;
    logic [AW-1:0]     w_wrIdx;
    logic [AW-1:0]     w_rdIdx;
    logic              w_unused;

    // Address phase is taken only while our own data phase is not stalling,
    // so a misbehaving HREADYin can never overlap two phases.
    assign w_accept   = i_hsel && i_hready && i_htrans[1] && r_hready;
    assign w_error    = (i_haddr >= 32'(BYTES))
                     || ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0)
                     || isOversize(i_hsize, DATA_WDT);
    assign w_acceptOk = w_accept && !w_error;
    assign w_rdEn     = w_acceptOk && !i_hwrite;
    assign w_commit   = r_pend && r_pendWrite && r_hready;
    assign w_wrIdx    = r_addr[LSB+AW-1:LSB];
    assign w_rdIdx    = i_haddr[LSB+AW-1:LSB];
    assign w_unused   = &{1'b0, i_hburst, i_htrans[0], r_addr[31:LSB+AW]};

    // Responder FSM with registered HREADYout/HRESP. IDLE and ERR2 both
    // sample new address phases; WAIT counts down the wait cycles; ERR1 is
    // the first (stalled) half of the two-cycle error response.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_state  <= ST_IDLE;
            r_wctr   <= '0;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_accept && w_error) begin
                        r_state  <= ST_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= HRESP_ERROR;
                    end else if (w_accept && (WAIT_STATES > 0)) begin
                        r_state  <= ST_WAIT;
                        r_wctr   <= 4'(WAIT_STATES);
                        r_hready <= 1'b0;
                        r_hresp  <= HRESP_OKAY;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (r_wctr == 4'd1) begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                    end else begin
                        r_wctr   <= r_wctr - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_ERROR;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Pending data phase bookkeeping. Only moves on edges where the current
    // data phase completes; errored transfers never become pending, so they
    // can never touch the RAM.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_pend      <= 1'b0;
            r_pendWrite <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
        end else if (r_hready) begin
            r_pend <= w_acceptOk;
            if (w_accept) begin
                r_addr      <= i_haddr;
                r_pendWrite <= i_hwrite;
                r_size      <= i_hsize;
            end
        end
    end

    // Lane enables: every lane sharing the same size-aligned group as the
    // address low bits is written (little-endian lane numbering).
    always_comb begin
        w_byteEn = '0;
        for (int b = 0; b < NB; b++) begin
            if ((b >> r_size) == (int'(r_addr[LSB-1:0]) >> r_size)) begin
                w_byteEn[b] = 1'b1;
            end
        end
    end

    ahb_slave_bytemem #(
        .DATA_WDT (DATA_WDT),
        .DEPTH    (DEPTH)
    ) u_mem (
        .i_clk    (i_hclk),
        .i_rst_n  (i_hreset_n),
        .i_wrEn   (w_commit),
        .i_wrIdx  (w_wrIdx),
        .i_byteEn (w_byteEn),
        .i_wdata  (i_hwdata),
        .i_rdEn   (w_rdEn),
        .i_rdIdx  (w_rdIdx),
        .i_rdClr  (r_hready),
        .o_rdata  (o_hrdata)
    );

    assign o_hready = r_hready;
    assign o_hresp  = r_hresp;

endmodule
